// File: rtl/cdctl_spi_slave.sv
// SPI mode-0 slave front end for the cdbus controller CSR bus (5-bit address, 8-bit data).
// Optional address auto-increment is compiled in with `define CD_SPI_ADDR_INC_EN.
module cdctl_spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       chip_select,
    output logic [4:0] csr_address,
    output logic       csr_read,
    input  logic [7:0] csr_readdata,
    output logic       csr_write,
    output logic [7:0] csr_writedata,
    input  logic       sck,
    input  logic       nss,
    input  logic       mosi,
    output logic       miso
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA_WR,
        DATA_RD
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] nss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_s, nss_s, mosi_s, sck_prev;
    logic                   sck_rise, sck_fall;

    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte;
    logic [7:0] tx_shift;
    logic       read_pending;
    logic       armed;
    logic       byte_done;

    logic       read_nxt, write_nxt;
    logic [4:0] addr_nxt;
    logic [7:0] wdata_nxt;
`ifdef CD_SPI_ADDR_INC_EN
    logic       addr_inc, addr_inc_nxt;
`endif

    // Synchronizers are left unreset so the live nss level is already known
    // when reset releases; resetting them could falsely arm mid-frame.
    always_ff @(posedge clk) begin
        sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
        nss_sync  <= {nss_sync[SYNC_STAGES-2:0], nss};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        sck_prev  <= sck_s;
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign nss_s    = nss_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;

    // rx_shift holds only the first seven bits; the eighth is taken live from
    // mosi_s so the byte can be acted on in the cycle it completes.
    assign rx_byte   = {rx_shift, mosi_s};
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != IDLE) && !nss_s;
    assign miso      = tx_shift[7];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (nss_s) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (armed) state_nxt = CMD;
                CMD:     if (byte_done) state_nxt = rx_byte[7] ? DATA_WR : DATA_RD;
                DATA_WR: state_nxt = DATA_WR;
                DATA_RD: state_nxt = DATA_RD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        read_nxt  = 1'b0;
        write_nxt = 1'b0;
        addr_nxt  = csr_address;
        wdata_nxt = csr_writedata;
`ifdef CD_SPI_ADDR_INC_EN
        addr_inc_nxt = addr_inc;
        if (addr_inc && (csr_write || read_pending)) begin
            addr_nxt = csr_address + 5'd1;
        end
`endif
        if (byte_done) begin
            unique case (state)
                CMD: begin
                    addr_nxt = rx_byte[4:0];
                    read_nxt = ~rx_byte[7];
`ifdef CD_SPI_ADDR_INC_EN
                    addr_inc_nxt = rx_byte[6];
`endif
                end
                DATA_WR: begin
                    write_nxt = 1'b1;
                    wdata_nxt = rx_byte;
                end
                DATA_RD: read_nxt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            csr_read      <= 1'b0;
            csr_write     <= 1'b0;
            csr_address   <= '0;
            csr_writedata <= '0;
`ifdef CD_SPI_ADDR_INC_EN
            addr_inc      <= 1'b0;
`endif
        end else begin
            csr_read      <= read_nxt;
            csr_write     <= write_nxt;
            csr_address   <= addr_nxt;
            csr_writedata <= wdata_nxt;
`ifdef CD_SPI_ADDR_INC_EN
            addr_inc      <= addr_inc_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chip_select  <= 1'b0;
            armed        <= 1'b0;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            read_pending <= 1'b0;
        end else begin
            chip_select  <= ~nss_s;
            armed        <= armed | nss_s;
            read_pending <= csr_read;

            if (nss_s || state == IDLE) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= {rx_shift[5:0], mosi_s};
            end

            // No shift on the fall with bit_cnt==0: that fall follows a byte
            // boundary and tx_shift may just have been reloaded.
            if (nss_s) begin
                tx_shift <= '0;
            end else if (read_pending) begin
                tx_shift <= csr_readdata;
            end else if (sck_fall && bit_cnt != 3'd0 && state != IDLE) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_cdctl_spi_slave.sv
// Scoreboard bench for cdctl_spi_slave: directed frames plus randomized CSR bursts.
// CSR strobes are checked by a monitor process against an expected-event queue.
module tb_cdctl_spi_slave;

    localparam int HALF = 8;

    logic       clk;
    logic       reset_n;
    logic       chip_select;
    logic [4:0] csr_address;
    logic       csr_read;
    logic [7:0] csr_readdata;
    logic       csr_write;
    logic [7:0] csr_writedata;
    logic       sck;
    logic       nss;
    logic       mosi;
    logic       miso;

    cdctl_spi_slave #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .chip_select  (chip_select),
        .csr_address  (csr_address),
        .csr_read     (csr_read),
        .csr_readdata (csr_readdata),
        .csr_write    (csr_write),
        .csr_writedata(csr_writedata),
        .sck          (sck),
        .nss          (nss),
        .mosi         (mosi),
        .miso         (miso)
    );

    typedef struct {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] frame_tx[$];
    logic [7:0] frame_miso[$];
    ev_t        mon_e;
    int         tests = 0;
    int         failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input logic wr, input logic [4:0] a, input logic [7:0] d);
        ev_t e;
        e.wr = wr;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n && (csr_read || csr_write)) begin
            check("rd_wr_exclusive", {31'd0, csr_read & csr_write}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, csr_read, csr_write}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_kind", {31'd0, csr_write}, {31'd0, mon_e.wr});
                check("csr_address", {27'd0, csr_address}, {27'd0, mon_e.addr});
                if (mon_e.wr) check("csr_writedata", {24'd0, csr_writedata}, {24'd0, mon_e.data});
            end
            if (csr_read) csr_readdata = (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
        end
    end

    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        repeat (HALF) @(negedge clk);
        m = miso;
        sck = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] d, output logic [7:0] r);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(d[i], m);
            r[i] = m;
        end
    endtask

    task automatic run_frame();
        logic [7:0] r;
        @(negedge clk);
        nss = 1'b0;
        repeat (HALF) @(negedge clk);
        foreach (frame_tx[i]) begin
            spi_byte(frame_tx[i], r);
            if (i < frame_miso.size()) check("miso_byte", {24'd0, r}, {24'd0, frame_miso[i]});
        end
        repeat (HALF) @(negedge clk);
        nss = 1'b1;
        repeat (4 * HALF) @(negedge clk);
        check("events_drained", exp_q.size(), 32'd0);
        frame_tx.delete();
        frame_miso.delete();
        rd_q.delete();
    endtask

    // Reference: writes land at addr+i, reads issue N+1 strobes; MISO byte k
    // carries the value returned by read k-1, byte 0 is zero.
    task automatic rand_frame();
        logic [7:0] cmd, v;
        logic [4:0] a;
        logic       inc;
        int         n;
        cmd = 8'($urandom);
        a   = cmd[4:0];
        inc = 1'b0;
`ifdef CD_SPI_ADDR_INC_EN
        inc = cmd[6];
`endif
        n = int'($urandom_range(0, 4));
        frame_tx.push_back(cmd);
        frame_miso.push_back(8'h00);
        if (cmd[7]) begin
            for (int i = 0; i < n; i++) begin
                v = 8'($urandom);
                frame_tx.push_back(v);
                frame_miso.push_back(8'h00);
                push_ev(1'b1, a, v);
                a = a + 5'(inc);
            end
        end else begin
            for (int j = 0; j <= n; j++) begin
                v = 8'($urandom);
                rd_q.push_back(v);
                push_ev(1'b0, a, 8'h00);
                a = a + 5'(inc);
                if (j < n) begin
                    frame_tx.push_back(8'($urandom));
                    frame_miso.push_back(v);
                end
            end
        end
        run_frame();
    endtask

    initial begin
        logic       m;
        logic [7:0] r;
        reset_n = 1'b0;
        nss = 1'b1;
        sck = 1'b0;
        mosi = 1'b0;
        csr_readdata = 8'h00;
        repeat (4) @(negedge clk);
        check("reset_chip_select", {31'd0, chip_select}, 32'd0);
        check("reset_csr_read", {31'd0, csr_read}, 32'd0);
        check("reset_csr_write", {31'd0, csr_write}, 32'd0);
        check("reset_csr_address", {27'd0, csr_address}, 32'd0);
        check("reset_csr_writedata", {24'd0, csr_writedata}, 32'd0);
        check("reset_miso", {31'd0, miso}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write burst
        frame_tx = '{8'h83, 8'h5A, 8'hA5};
        frame_miso = '{8'h00, 8'h00, 8'h00};
        push_ev(1'b1, 5'd3, 8'h5A);
        push_ev(1'b1, 5'd3, 8'hA5);
        run_frame();

        // Read burst with prefetch
        frame_tx = '{8'h05, 8'hFF, 8'hFF};
        frame_miso = '{8'h00, 8'h11, 8'h22};
        rd_q = '{8'h11, 8'h22, 8'h33};
        push_ev(1'b0, 5'd5, 8'h00);
        push_ev(1'b0, 5'd5, 8'h00);
        push_ev(1'b0, 5'd5, 8'h00);
        run_frame();

        // Partial trailing byte is dropped
        @(negedge clk);
        nss = 1'b0;
        repeat (HALF) @(negedge clk);
        push_ev(1'b1, 5'd2, 8'h3C);
        spi_byte(8'h82, r);
        spi_byte(8'h3C, r);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
        repeat (HALF) @(negedge clk);
        nss = 1'b1;
        repeat (4 * HALF) @(negedge clk);
        check("partial_events_drained", exp_q.size(), 32'd0);
        check("partial_chip_select", {31'd0, chip_select}, 32'd0);

        // Reset during the 3rd bit of a data byte, nss held low throughout
        @(negedge clk);
        nss = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_byte(8'h81, r);
        spi_bit(1'b0, m);
        spi_bit(1'b1, m);
        mosi = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_chip_select", {31'd0, chip_select}, 32'd0);
        reset_n = 1'b1;
        repeat (HALF - 4) @(negedge clk);
        sck = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
        for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
        spi_byte(8'h99, r);
        spi_byte(8'h81, r);
        spi_byte(8'h66, r);
        repeat (HALF) @(negedge clk);
        nss = 1'b1;
        repeat (4 * HALF) @(negedge clk);
        check("midreset_no_strobes", exp_q.size(), 32'd0);
        frame_tx = '{8'h81, 8'h77};
        frame_miso = '{8'h00, 8'h00};
        push_ev(1'b1, 5'd1, 8'h77);
        run_frame();

        // nss rises on the same clk as the 8th sck rise of a write data byte
        @(negedge clk);
        nss = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_byte(8'h84, r);
        for (int i = 0; i < 7; i++) spi_bit(1'b1, m);
        mosi = 1'b0;
        repeat (HALF) @(negedge clk);
        sck = 1'b1;
        nss = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
        repeat (4 * HALF) @(negedge clk);
        check("nss_wins_no_write", exp_q.size(), 32'd0);

`ifdef CD_SPI_ADDR_INC_EN
        frame_tx = '{8'hDF, 8'h01, 8'h02};
        frame_miso = '{8'h00, 8'h00, 8'h00};
        push_ev(1'b1, 5'd31, 8'h01);
        push_ev(1'b1, 5'd0, 8'h02);
        run_frame();
`endif

        for (int k = 0; k < 30; k++) rand_frame();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, failed);
        $fatal(1);
    end

endmodule
